// File: rtl/responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : responder_pkg
// Description : Shared state encoding, score width and saturating score
//               helpers for the quiz-buzzer responder arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package responder_pkg;

   localparam int c_num_players = 4;
   localparam int c_score_w     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_ANSWER = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   typedef logic [c_score_w-1:0] score_t;

   // Add one, holding at the all-ones ceiling
   function automatic score_t sat_inc(input score_t s);
      return (s == '1) ? s : score_t'(s + 1'b1);
   endfunction

   // Subtract one, holding at the zero floor
   function automatic score_t sat_dec(input score_t s);
      return (s == '0) ? s : score_t'(s - 1'b1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider producing a one-cycle tick every
//               TICK_DIV clocks; clr restarts the count from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
   parameter int TICK_DIV = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // Count 0..TICK_DIV-1 and wrap; a clear forces the count back to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (clr || (r_cnt == c_last))
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   // A clear in the same cycle suppresses the pulse so a new phase starts clean
   assign tick = !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/responder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : responder_arbiter
// Description : Four-player quiz buzzer: foul tracking, round-robin lock of
//               the first eligible press, answer countdown and saturating
//               per-player scores.
// Revision    : 1.0 - initial release
// ============================================================================
module responder_arbiter
   import responder_pkg::*;
#(
   parameter int TICK_DIV  = 100000000,
   parameter int OPEN_TIME = 30,
   parameter int ANS_TIME  = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        starttimer,
   input  logic [3:0]  player,
   input  logic        yes,
   input  logic        no,
   input  logic        nextset,
   output logic [1:0]  state,
   output logic [1:0]  winner,
   output logic        winner_vld,
   output logic [5:0]  remain,
   output logic [3:0]  foul,
   output logic [15:0] score
);

   localparam logic [5:0] c_open_load = 6'(OPEN_TIME);
   localparam logic [5:0] c_ans_load  = 6'(ANS_TIME);

   // {nextset, no, yes, starttimer, player[3:0]}
   logic [7:0]       r_sync;
   logic [7:0]       r_prev;
   logic [7:0]       w_edge;

   state_t           r_state;
   logic [1:0]       r_winner;
   logic             r_vld;
   logic [5:0]       r_remain;
   logic [3:0]       r_foul;
   logic [1:0]       r_rr_ptr;
   logic [3:0][3:0]  r_score;

   logic [3:0]       w_press;
   logic             w_start_e;
   logic             w_yes_e;
   logic             w_no_e;
   logic             w_next_e;
   logic [3:0]       w_elig;
   logic             w_pick_vld;
   logic [1:0]       w_pick;
   logic [1:0]       w_idx;
   logic             w_lock;
   logic             w_tick;
   logic             w_div_clr;
   logic             w_last_tick;

   // Register input levels, then keep one more copy so a press is a 0->1 change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {nextset, no, yes, starttimer, player};
         r_prev <= r_sync;
      end
   end

   assign w_edge    = r_sync & ~r_prev;
   assign w_press   = w_edge[3:0];
   assign w_start_e = w_edge[4];
   assign w_yes_e   = w_edge[5];
   assign w_no_e    = w_edge[6];
   assign w_next_e  = w_edge[7];

   // Fouled players cannot compete for the lock this round
   assign w_elig = w_press & ~r_foul;

   // Round-robin pick: scan from the pointer upward, the first hit wins
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick     = '0;
      w_idx      = '0;
      for (int i = 3; i >= 0; i--) begin
         w_idx = r_rr_ptr + 2'(i);
         if (w_elig[w_idx]) begin
            w_pick_vld = 1'b1;
            w_pick     = w_idx;
         end
      end
   end

   assign w_lock      = (r_state == ST_OPEN) && !w_next_e && w_pick_vld;
   assign w_div_clr   = (r_state == ST_IDLE) || (r_state == ST_RESULT) || w_lock;
   assign w_last_tick = w_tick && (r_remain <= 6'd1);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_div_clr),
      .tick (w_tick)
   );

   // Round sequencing, lock, countdown and scoring
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_winner <= '0;
         r_vld    <= 1'b0;
         r_remain <= '0;
         r_foul   <= '0;
         r_rr_ptr <= '0;
         r_score  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_foul <= r_foul | w_press;
               if (w_start_e) begin
                  r_state  <= ST_OPEN;
                  r_remain <= c_open_load;
               end
            end
            ST_OPEN: begin
               if (w_next_e) begin
                  r_state <= ST_IDLE;
                  r_foul  <= '0;
                  r_vld   <= 1'b0;
               end else if (w_pick_vld) begin
                  // A press beats a coinciding expiry
                  r_state  <= ST_ANSWER;
                  r_winner <= w_pick;
                  r_vld    <= 1'b1;
                  r_rr_ptr <= w_pick + 2'd1;
                  r_remain <= c_ans_load;
               end else if (w_tick) begin
                  if (r_remain != '0)
                     r_remain <= r_remain - 6'd1;
                  if (w_last_tick) begin
                     r_state <= ST_RESULT;
                     r_vld   <= 1'b0;
                  end
               end
            end
            ST_ANSWER: begin
               if (w_next_e) begin
                  r_state <= ST_IDLE;
                  r_foul  <= '0;
                  r_vld   <= 1'b0;
               end else begin
                  if (w_tick && (r_remain != '0))
                     r_remain <= r_remain - 6'd1;
                  // A wrong answer outranks a simultaneous right answer
                  if (w_no_e || w_last_tick) begin
                     r_score[r_winner] <= sat_dec(r_score[r_winner]);
                     r_state           <= ST_RESULT;
                  end else if (w_yes_e) begin
                     r_score[r_winner] <= sat_inc(r_score[r_winner]);
                     r_state           <= ST_RESULT;
                  end
               end
            end
            ST_RESULT: begin
               if (w_next_e) begin
                  r_state <= ST_IDLE;
                  r_foul  <= '0;
                  r_vld   <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign state      = r_state;
   assign winner     = r_winner;
   assign winner_vld = r_vld;
   assign remain     = r_remain;
   assign foul       = r_foul;
   assign score      = r_score;

endmodule
`default_nettype wire

// File: doc/responder_arbiter.md
RESPONDER_ARBITER -- requirements
Module: responder_arbiter

Interface
REQ-001 Parameter TICK_DIV, default 100000000; clk cycles per countdown tick (1 s at 100 MHz).
REQ-002 Parameter OPEN_TIME, default 30; ticks in the buzz-in window.
REQ-003 Parameter ANS_TIME, default 20; ticks allowed for the winner's answer.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 starttimer  in  1  host opens a round; synchronous, debounced level.
REQ-007 player  in  4  buzzer levels; bit i = player i+1; synchronous, debounced.
REQ-008 yes  in  1  judge: answer correct.
REQ-009 no  in  1  judge: answer wrong.
REQ-010 nextset  in  1  judge: clear the result and return to idle.
REQ-011 state  out  2  0 IDLE, 1 OPEN, 2 ANSWER, 3 RESULT.
REQ-012 winner  out  2  index of the locked player; valid only when winner_vld=1.
REQ-013 winner_vld  out  1  a player holds the lock.
REQ-014 remain  out  6  ticks left in the current OPEN or ANSWER phase, for the 7-segment display.
REQ-015 foul  out  4  per-player early-press flags for the current round.
REQ-016 score  out  16  four 4-bit scores; player i in [4i+3:4i].

Function
REQ-017 Inputs are edge-detected internally; a press is the 0->1 transition of a registered level, and a held level never re-triggers.
REQ-018 IDLE -> OPEN on a starttimer rising edge: remain loads OPEN_TIME, the tick divider clears, and foul is held.
REQ-019 A player press in IDLE sets that player's foul bit.
REQ-020 The foul bit stays set until the next nextset-driven return to IDLE.
REQ-021 A fouled player's presses are ignored in OPEN.
REQ-022 OPEN, on one or more eligible press edges in a cycle, locks exactly one winner.
REQ-023 The winner is chosen by round-robin priority, starting at the player after the previous round's winner; player 1 is first after reset.
REQ-024 On lock: winner_vld=1, winner is set, state -> ANSWER next cycle, remain loads ANS_TIME, the divider clears.
REQ-025 Lock latency is 2 cycles from the press level rising to winner_vld: 1 cycle for the sync register, 1 cycle for the arbitration register.
REQ-026 remain decrements once per tick, when the divider reaches TICK_DIV-1.
REQ-027 In OPEN, reaching remain=0 moves to RESULT with winner_vld=0 and no score change.
REQ-028 If a press and expiry coincide in OPEN, the press wins.
REQ-029 In ANSWER, a yes edge adds 1 to the winner's score, saturating at 15, and moves to RESULT.
REQ-030 In ANSWER, a no edge, or remain reaching 0, subtracts 1 from the winner's score, saturating at 0, and moves to RESULT.
REQ-031 If yes and no occur in the same cycle, no is applied and yes is ignored.
REQ-032 RESULT holds winner, winner_vld and remain frozen; a nextset edge -> IDLE, clears foul and winner_vld, and keeps scores.
REQ-033 yes, no and nextset are ignored outside the states named above.
REQ-034 starttimer is ignored outside IDLE.
REQ-035 A nextset edge in OPEN or ANSWER aborts the round to IDLE with no score change.

Reset
REQ-036 rst asserted: state=IDLE, winner=0, winner_vld=0, remain=0, foul=0, score=0, round-robin pointer=player 1, divider=0, edge registers=0.
REQ-037 Reset mid-round takes effect immediately; there is no pending-score side effect.

Structure
REQ-038 State encoding constants and the score width (4) live in the shared package responder_pkg.
REQ-039 The tick divider is a sub-module, tick_gen (inputs clk, rst, clr; output 1-cycle tick pulse).
REQ-040 Arbitration and scoring stay in responder_arbiter.

Verification
REQ-041 Run the bench with TICK_DIV=4, OPEN_TIME=3, ANS_TIME=2.
REQ-042 Press player 1 in OPEN, then yes -> winner=0, state ANSWER, then RESULT; score[3:0]=1.
REQ-043 Press players 2 and 4 in the same cycle with the previous winner = player 1 -> winner=1 (player 2); next round, players 2 and 4 pressed together -> winner=3.
REQ-044 Press player 3 in IDLE, then start the round; player 3 presses again -> foul=4'b0100, no lock; player 3 alone is ignored until OPEN expires at 12 clk -> RESULT, winner_vld=0.
REQ-045 Lock player 4 and send no edges only -> ANSWER times out after 8 clk; score[15:12] stays 0 (floor); 16 yes rounds for player 4 -> score 15 (ceiling).
REQ-046 Assert rst during ANSWER -> all outputs return to their reset values asynchronously, before the next clk edge.
REQ-047 yes and no in the same cycle -> treated as no.
REQ-048 A held starttimer after nextset does not reopen the round.
